dcache_dm: RTL and testbench



---
 rtl/dcache_dm.sv | 230 +++++++++++++++++++++++
 tb/tb_dcache_dm.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, write-through, no-write-allocate data cache.
// Sits between the CPU load/store stage and a word-addressed backing memory.
// Each line holds one 32-bit word plus a valid bit and a tag. Loads that miss
// are filled from memory. Stores always go to memory, and update the line
// only when they hit. A flush walks every index and clears one valid bit per
// cycle. Hit and miss counters saturate at all-ones.
//
// Handshake rules (both sides):
//   CPU side: cpu_req is a level that is held, with its fields stable, until
//   the cache returns a one-cycle cpu_ready pulse. cpu_req is sampled only in
//   IDLE and never in the cycle where cpu_ready is high. That cycle therefore
//   never starts a new request, and the next request is taken one cycle later.
//   Memory side: mem_req and all mem_* fields are registered and held stable
//   until mem_ack is seen with mem_req high. mem_ack may come in the same cycle
//   mem_req first rises. mem_ack is ignored at every other time.
module dcache_dm #(
    parameter int INDEX_W = 6,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [3:0]        cpu_be,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    input  logic              flush,
    output logic              flushing,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt,
    output logic [2:0]        dbg_state
);

    localparam int LINES  = 1 << INDEX_W;
    localparam int WORD_W = ADDR_W - 2;
    localparam int TAG_W  = WORD_W - INDEX_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_FILL   = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP   = 3'd4,
        S_FLUSH  = 3'd5
    } state_t;

    state_t              state;

    // Request captured in IDLE. The byte offset is dropped because the cache
    // and memory are word-addressed.
    logic                req_we;
    logic [WORD_W-1:0]   req_word;
    logic [3:0]          req_be;
    logic [31:0]         req_wdata;
    logic                req_hit;

    logic                flush_pend;
    logic [INDEX_W-1:0]  flush_cnt;

    // Line storage. Only the valid bits need a reset value.
    logic [LINES-1:0]    valid;
    logic [TAG_W-1:0]    tag_arr  [LINES];
    logic [31:0]         data_arr [LINES];

    logic [INDEX_W-1:0]  req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [31:0]         line_data;
    logic                lookup_hit;
    logic                fill_done;
    logic                write_done;
    logic [31:0]         merged_data;

    // The low address bits select a byte lane, and cpu_be already covers that.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign req_idx    = req_word[INDEX_W-1:0];
    assign req_tag    = req_word[WORD_W-1:INDEX_W];
    assign line_data  = data_arr[req_idx];
    assign lookup_hit = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign fill_done  = (state == S_FILL)  && mem_req && mem_ack;
    assign write_done = (state == S_WRITE) && mem_req && mem_ack;
    assign dbg_state  = state;

    // Merge the enabled store byte lanes into the current line word.
    always_comb begin
        merged_data = line_data;
        for (int b = 0; b < 4; b++) begin
            if (req_be[b]) begin
                merged_data[8*b +: 8] = req_wdata[8*b +: 8];
            end
        end
    end

    // Control FSM with registered CPU and memory outputs, valid bits and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cpu_ready  <= 1'b0;
            cpu_rdata  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            flushing   <= 1'b0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            valid      <= '0;
            flush_pend <= 1'b0;
            flush_cnt  <= '0;
            req_we     <= 1'b0;
            req_word   <= '0;
            req_be     <= '0;
            req_wdata  <= '0;
            req_hit    <= 1'b0;
        end else begin
            cpu_ready <= 1'b0;

            // A flush that arrives mid-operation waits until the next IDLE.
            if (flush && (state != S_IDLE)) begin
                flush_pend <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (flush || flush_pend) begin
                        flush_pend <= 1'b0;
                        flush_cnt  <= '0;
                        flushing   <= 1'b1;
                        state      <= S_FLUSH;
                    end else if (cpu_req && !cpu_ready) begin
                        req_we    <= cpu_we;
                        req_word  <= cpu_addr[ADDR_W-1:2];
                        req_be    <= cpu_be;
                        req_wdata <= cpu_wdata;
                        state     <= S_LOOKUP;
                    end
                end

                S_LOOKUP: begin
                    req_hit <= lookup_hit;
                    if (lookup_hit) begin
                        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
                    end else begin
                        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
                    end

                    if (req_we) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= {req_word, 2'b00};
                        mem_be    <= req_be;
                        mem_wdata <= req_wdata;
                        state     <= S_WRITE;
                    end else if (lookup_hit) begin
                        cpu_rdata <= line_data;
                        cpu_ready <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        mem_we    <= 1'b0;
                        mem_addr  <= {req_word, 2'b00};
                        mem_be    <= 4'b0000;
                        mem_wdata <= '0;
                        state     <= S_FILL;
                    end
                end

                S_FILL: begin
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                    end else if (mem_ack) begin
                        mem_req          <= 1'b0;
                        valid[req_idx]   <= 1'b1;
                        cpu_rdata        <= mem_rdata;
                        cpu_ready        <= 1'b1;
                        state            <= S_RESP;
                    end
                end

                S_WRITE: begin
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                    end else if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        cpu_ready <= 1'b1;
                        state     <= S_RESP;
                    end
                end

                S_RESP: begin
                    state <= S_IDLE;
                end

                S_FLUSH: begin
                    valid[flush_cnt] <= 1'b0;
                    flush_cnt        <= flush_cnt + 1'b1;
                    if (&flush_cnt) begin
                        flushing <= 1'b0;
                        state    <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Tag and data array writes: a fill installs a line, and a store hit merges bytes.
    always_ff @(posedge clk) begin
        if (!rst && fill_done) begin
            tag_arr[req_idx]  <= req_tag;
            data_arr[req_idx] <= mem_rdata;
        end else if (!rst && write_done && req_hit) begin
            data_arr[req_idx] <= merged_data;
        end
    end

endmodule

// File: tb/tb_dcache_dm.sv
// Directed testbench for dcache_dm. It plays the role of the CPU and of a
// hand-driven backing memory. Every expected value is written out by hand.
module tb_dcache_dm;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        flush;
    logic        flushing;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    logic [2:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    dcache_dm #(.INDEX_W(6), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_be    (cpu_be),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .flush     (flush),
        .flushing  (flushing),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt),
        .dbg_state (dbg_state)
    );

    // Clock generation: 10 time-unit period.
    always #5 clk = ~clk;

    // Advance to just after the next rising edge. All driving and sampling happens here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_be    = be;
        cpu_wdata = wdata;
        cpu_req   = 1'b1;
    endtask

    // mem_req is expected 3 edges after the request is driven.
    task automatic wait_mem(input string tag);
        int n;
        n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_memreq_lat"}, 32'(n), 32'd3);
    endtask

    task automatic miss_load(input string tag, input logic [31:0] addr, input logic [31:0] data);
        issue(1'b0, addr, 4'b0000, 32'h0);
        wait_mem(tag);
        chk({tag, "_mem_addr"}, mem_addr, addr);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        tick();
        tick();
        chk({tag, "_mem_req_held"}, 32'(mem_req), 32'd1);
        chk({tag, "_no_early_ready"}, 32'(cpu_ready), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = data;
        tick();
        mem_ack = 1'b0;
        chk({tag, "_ready"}, 32'(cpu_ready), 32'd1);
        chk({tag, "_rdata"}, cpu_rdata, data);
        chk({tag, "_mem_req_drop"}, 32'(mem_req), 32'd0);
        cpu_req = 1'b0;
        tick();
        chk({tag, "_ready_pulse"}, 32'(cpu_ready), 32'd0);
    endtask

    task automatic hit_load(input string tag, input logic [31:0] addr, input logic [31:0] data);
        issue(1'b0, addr, 4'b0000, 32'h0);
        tick();
        chk({tag, "_ready_early"}, 32'(cpu_ready), 32'd0);
        tick();
        chk({tag, "_ready"}, 32'(cpu_ready), 32'd1);
        chk({tag, "_rdata"}, cpu_rdata, data);
        chk({tag, "_no_mem_req"}, 32'(mem_req), 32'd0);
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic store_op(input string tag, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] data, input logic [31:0] old_rdata);
        issue(1'b1, addr, be, data);
        wait_mem(tag);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd1);
        chk({tag, "_mem_be"}, 32'(mem_be), 32'(be));
        chk({tag, "_mem_wdata"}, mem_wdata, data);
        chk({tag, "_mem_addr"}, mem_addr, addr);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk({tag, "_ready"}, 32'(cpu_ready), 32'd1);
        chk({tag, "_rdata_kept"}, cpu_rdata, old_rdata);
        cpu_req = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_be    = '0;
        cpu_wdata = '0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        tick();
        tick();

        // Reset values
        chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_flushing", 32'(flushing), 32'd0);
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        tick();

        // Cold load miss, then a hit on the same address
        miss_load("a_ld100", 32'h100, 32'hDEADBEEF);
        chk("a_miss_cnt", miss_cnt, 32'd1);
        chk("a_hit_cnt", hit_cnt, 32'd0);

        // The hit is held one cycle past cpu_ready; that cycle must not start a new request
        issue(1'b0, 32'h100, 4'b0000, 32'h0);
        tick();
        chk("b_no_mem_req", 32'(mem_req), 32'd0);
        chk("b_ready_early", 32'(cpu_ready), 32'd0);
        tick();
        chk("b_ready", 32'(cpu_ready), 32'd1);
        chk("b_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("b_hit_cnt", hit_cnt, 32'd1);
        tick();
        chk("b_ready_pulse", 32'(cpu_ready), 32'd0);
        cpu_req = 1'b0;
        tick();
        tick();
        chk("b_no_reissue_hits", hit_cnt, 32'd1);
        chk("b_no_reissue_ready", 32'(cpu_ready), 32'd0);

        // Store hit on byte lane 0 is merged into the line
        store_op("c_st100", 32'h100, 4'b0001, 32'h11223344, 32'hDEADBEEF);
        chk("c_st_hit_cnt", hit_cnt, 32'd2);
        hit_load("c_ld100", 32'h100, 32'hDEADBE44);
        chk("c_ld_hit_cnt", hit_cnt, 32'd3);

        // Conflict on index 0: 0x200 evicts 0x100
        miss_load("d_ld200", 32'h200, 32'hCAFEF00D);
        chk("d_miss_cnt1", miss_cnt, 32'd2);
        miss_load("d_ld100", 32'h100, 32'h12345678);
        chk("d_miss_cnt2", miss_cnt, 32'd3);

        // A store miss writes memory but does not allocate a line
        store_op("e_st300", 32'h300, 4'b1111, 32'hA5A5A5A5, 32'h12345678);
        chk("e_st_miss_cnt", miss_cnt, 32'd4);
        hit_load("e_ld100", 32'h100, 32'h12345678);
        chk("e_hit_cnt", hit_cnt, 32'd4);
        miss_load("e_ld300", 32'h300, 32'h0BADF00D);
        chk("e_ld_miss_cnt", miss_cnt, 32'd5);

        // Flush pulsed during a fill; a request held during the walk is taken afterwards
        miss_load("f_ld104", 32'h104, 32'h44444444);
        issue(1'b0, 32'h108, 4'b0000, 32'h0);
        wait_mem("f_ld108");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("f_fill_not_flushing", 32'(flushing), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h88888888;
        tick();
        mem_ack = 1'b0;
        chk("f_fill_ready", 32'(cpu_ready), 32'd1);
        chk("f_fill_rdata", cpu_rdata, 32'h88888888);
        issue(1'b0, 32'h100, 4'b0000, 32'h0);
        tick();
        chk("f_resp_flushing", 32'(flushing), 32'd0);
        tick();
        chk("f_flush_start", 32'(flushing), 32'd1);
        n = 1;
        while (flushing && n < 100) begin
            tick();
            if (flushing) n++;
        end
        chk("f_flush_len", 32'(n), 32'd64);
        wait_mem("f_ld100_after");
        chk("f_ld100_we", 32'(mem_we), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h11111111;
        tick();
        mem_ack = 1'b0;
        chk("f_ld100_ready", 32'(cpu_ready), 32'd1);
        chk("f_ld100_rdata", cpu_rdata, 32'h11111111);
        cpu_req = 1'b0;
        tick();
        chk("f_miss_cnt", miss_cnt, 32'd8);
        chk("f_hit_cnt_kept", hit_cnt, 32'd4);
        miss_load("f_ld104b", 32'h104, 32'h55555555);
        miss_load("f_ld108b", 32'h108, 32'h66666666);
        chk("f_miss_cnt_end", miss_cnt, 32'd10);

        // Reset during a fill abandons it without a cpu_ready
        issue(1'b0, 32'h10C, 4'b0000, 32'h0);
        wait_mem("g_ld10c");
        tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        cpu_req = 1'b0;
        chk("g_mem_req", 32'(mem_req), 32'd0);
        chk("g_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("g_hit_cnt", hit_cnt, 32'd0);
        chk("g_miss_cnt", miss_cnt, 32'd0);
        chk("g_state", 32'(dbg_state), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF0000;
        tick();
        mem_ack = 1'b0;
        chk("g_late_ack_ready", 32'(cpu_ready), 32'd0);
        tick();
        chk("g_late_ack_ready2", 32'(cpu_ready), 32'd0);
        chk("g_late_ack_rdata", cpu_rdata, 32'd0);
        miss_load("g_ld100", 32'h100, 32'h77777777);
        chk("g_miss_cnt_after", miss_cnt, 32'd1);
        chk("g_hit_cnt_after", hit_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
